// File: rtl/pill_line_plant_sim.sv
// Plant model of the bottling line hopper and conveyor.
// Produces pill pulses, bottle-in-place and conveyor status from controller
// commands, with fault switches (hopper stop, conveyor jam), manual pill and
// refill buttons, and BCD tallies of pills emitted and bottles moved.
module pill_line_plant_sim #(
  parameter int PILL_PERIOD = 1000,
  parameter int PULSE_W     = 100,
  parameter int MOVE_TIME   = 2000,
  parameter int STOCK_INIT  = 500,
  parameter int STOCK_W     = 10
) (
  input  logic        clk_1khz,
  input  logic        switch_clr,
  input  logic        run_req,
  input  logic        switch_req,
  input  logic        hopper_stop,
  input  logic        conveyor_stop,
  input  logic        manual_add,
  input  logic        refill,
  output logic        pill_pulse,
  output logic        bottle_in_place,
  output logic        conveyor_ok,
  output logic        hopper_empty,
  output logic [11:0] pill_bcd,
  output logic [7:0]  bottle_bcd
);
  localparam int PW = $clog2(PILL_PERIOD + 1);
  localparam int WW = $clog2(PULSE_W + 1);
  localparam int MW = $clog2(MOVE_TIME + 1);
  localparam logic [PW-1:0]      PER_LAST   = PW'(PILL_PERIOD - 1);
  localparam logic [WW-1:0]      PULSE_LAST = WW'(PULSE_W - 1);
  localparam logic [MW-1:0]      MOVE_LAST  = MW'(MOVE_TIME - 1);
  localparam logic [STOCK_W-1:0] STOCK_RST  = STOCK_W'(STOCK_INIT);

  typedef enum logic [1:0] {IDLE, DISPENSE, MOVING, JAMMED} state_t;

  state_t             state, nxt;
  logic [PW-1:0]      period_cnt;
  logic [WW-1:0]      pulse_cnt;
  logic [MW-1:0]      move_cnt;
  logic [STOCK_W-1:0] stock;
  logic [2:0]         man_sync, ref_sync;
  logic               sw_q;
  logic               sw_edge, man_edge, ref_edge;
  logic               move_done, bottle_done, auto_pill, emit;

  function automatic logic [3:0] dinc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [11:0] bcd3_inc(input logic [11:0] v);
    logic [11:0] r;
    r[3:0]  = dinc(v[3:0]);
    r[7:4]  = (v[3:0] == 4'd9) ? dinc(v[7:4]) : v[7:4];
    r[11:8] = (v[7:0] == 8'h99) ? dinc(v[11:8]) : v[11:8];
    return r;
  endfunction

  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    logic [7:0] r;
    r[3:0] = dinc(v[3:0]);
    r[7:4] = (v[3:0] == 4'd9) ? dinc(v[7:4]) : v[7:4];
    return r;
  endfunction

  // buttons go through two sync flops, the third flop gives the rising edge;
  // switch_req comes from on-board logic and only needs edge detection
  always_ff @(posedge clk_1khz or negedge switch_clr)
    if (!switch_clr) begin
      man_sync <= '0;
      ref_sync <= '0;
      sw_q     <= 1'b0;
    end else begin
      man_sync <= {man_sync[1:0], manual_add};
      ref_sync <= {ref_sync[1:0], refill};
      sw_q     <= switch_req;
    end

  assign sw_edge     = switch_req & ~sw_q;
  assign man_edge    = man_sync[1] & ~man_sync[2];
  assign ref_edge    = ref_sync[1] & ~ref_sync[2];
  assign move_done   = (state == MOVING) && (move_cnt == MOVE_LAST);
  assign bottle_done = ~conveyor_stop & (move_done | (state == JAMMED));
  // a pulse still running swallows the automatic slot rather than overlapping
  assign auto_pill   = (state == DISPENSE) && (period_cnt == '0) && !hopper_stop &&
                       (stock != '0) && !pill_pulse;
  assign emit        = auto_pill | (man_edge & ~pill_pulse);

  // state register
  always_ff @(posedge clk_1khz or negedge switch_clr)
    if (!switch_clr) state <= IDLE;
    else             state <= nxt;

  // next-state: a bottle request beats run_req; requests while moving are ignored
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (sw_edge) nxt = MOVING; else if (run_req) nxt = DISPENSE;
      DISPENSE: if (sw_edge) nxt = MOVING; else if (!run_req) nxt = IDLE;
      MOVING:   if (move_done) nxt = conveyor_stop ? JAMMED : (run_req ? DISPENSE : IDLE);
      JAMMED:   if (!conveyor_stop) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // period and move timers; each restarts from zero whenever its state is left
  always_ff @(posedge clk_1khz or negedge switch_clr)
    if (!switch_clr) begin
      period_cnt <= '0;
      move_cnt   <= '0;
    end else begin
      if (state == DISPENSE && nxt == DISPENSE)
        period_cnt <= (period_cnt == PER_LAST) ? '0 : period_cnt + 1'b1;
      else
        period_cnt <= '0;
      move_cnt <= (state == MOVING && !move_done) ? move_cnt + 1'b1 : '0;
    end

  // pill pulse generator and pill tally; a started pulse always runs its full width
  always_ff @(posedge clk_1khz or negedge switch_clr)
    if (!switch_clr) begin
      pill_pulse <= 1'b0;
      pulse_cnt  <= '0;
      pill_bcd   <= '0;
    end else if (emit) begin
      pill_pulse <= 1'b1;
      pulse_cnt  <= PULSE_LAST;
      pill_bcd   <= bcd3_inc(pill_bcd);
    end else if (pill_pulse) begin
      if (pulse_cnt == '0) pill_pulse <= 1'b0;
      else                 pulse_cnt  <= pulse_cnt - 1'b1;
    end

  // hopper stock: refill wins over an automatic decrement; manual pills are free
  always_ff @(posedge clk_1khz or negedge switch_clr)
    if (!switch_clr) begin
      stock        <= STOCK_RST;
      hopper_empty <= 1'b0;
    end else begin
      if (ref_edge)       stock <= STOCK_RST;
      else if (auto_pill) stock <= stock - 1'b1;
      hopper_empty <= (stock == '0);
    end

  // conveyor outputs and bottle tally, aligned with the state register
  always_ff @(posedge clk_1khz or negedge switch_clr)
    if (!switch_clr) begin
      bottle_in_place <= 1'b1;
      conveyor_ok     <= 1'b0;
      bottle_bcd      <= '0;
    end else begin
      bottle_in_place <= !(nxt == MOVING || nxt == JAMMED);
      conveyor_ok     <= ~conveyor_stop & (state != JAMMED);
      if (bottle_done) bottle_bcd <= bcd2_inc(bottle_bcd);
    end
endmodule

// File: tb/tb_pill_line_plant_sim.sv
// Directed bench for pill_line_plant_sim: one full-size instance for the
// timing scenarios and one small-parameter instance for stock exhaustion,
// BCD wrap and asynchronous reset.
`timescale 1ns/1ps
module tb_pill_line_plant_sim;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic run_req, switch_req, hopper_stop, conveyor_stop, manual_add, refill;
  logic pp_a, bip_a, cok_a, emp_a, pp_b, bip_b, cok_b, emp_b;
  logic [11:0] pbcd_a, pbcd_b;
  logic [7:0]  bbcd_a, bbcd_b;
  int pe = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) pe <= pe + 1;

  pill_line_plant_sim u_a (
    .clk_1khz(clk), .switch_clr(rst_a), .run_req(run_req), .switch_req(switch_req),
    .hopper_stop(hopper_stop), .conveyor_stop(conveyor_stop), .manual_add(manual_add),
    .refill(refill), .pill_pulse(pp_a), .bottle_in_place(bip_a), .conveyor_ok(cok_a),
    .hopper_empty(emp_a), .pill_bcd(pbcd_a), .bottle_bcd(bbcd_a));

  pill_line_plant_sim #(.PILL_PERIOD(8), .PULSE_W(2), .MOVE_TIME(4), .STOCK_INIT(2),
                        .STOCK_W(4)) u_b (
    .clk_1khz(clk), .switch_clr(rst_b), .run_req(run_req), .switch_req(switch_req),
    .hopper_stop(hopper_stop), .conveyor_stop(conveyor_stop), .manual_add(manual_add),
    .refill(refill), .pill_pulse(pp_b), .bottle_in_place(bip_b), .conveyor_ok(cok_b),
    .hopper_empty(emp_b), .pill_bcd(pbcd_b), .bottle_bcd(bbcd_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int n);
    while (pe < n) @(negedge clk);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int b, e, m, h, c, cnt, rise, prev;
    rst_a = 0; rst_b = 0;
    run_req = 0; switch_req = 0; hopper_stop = 0; conveyor_stop = 0;
    manual_add = 0; refill = 0;
    cyc(3);
    chk("rst_pulse", pp_a, 0);
    chk("rst_bip", bip_a, 1);
    chk("rst_cok", cok_a, 0);
    chk("rst_empty", emp_a, 0);
    chk("rst_pill_bcd", pbcd_a, 0);
    chk("rst_bottle_bcd", bbcd_a, 0);
    chk("rst_stock", u_a.stock, 500);

    // 1: continuous dispensing, one pill per second
    rst_a = 1; run_req = 1; b = pe;
    wait_to(b + 1);    chk("t1_no_pulse_yet", pp_a, 0); chk("t1_cok", cok_a, 1);
    wait_to(b + 2);    chk("t1_rise1", pp_a, 1); chk("t1_bcd1", pbcd_a, 12'h001);
    wait_to(b + 101);  chk("t1_width_end", pp_a, 1);
    wait_to(b + 102);  chk("t1_fall1", pp_a, 0);
    wait_to(b + 1001); chk("t1_pre_rise2", pp_a, 0);
    wait_to(b + 1002); chk("t1_rise2", pp_a, 1);
    wait_to(b + 1102); chk("t1_fall2", pp_a, 0);
    wait_to(b + 2002); chk("t1_rise3", pp_a, 1); chk("t1_bcd3", pbcd_a, 12'h003);
    wait_to(b + 3000);
    chk("t1_bcd_end", pbcd_a, 12'h003);
    chk("t1_stock", u_a.stock, 497);

    // 2: bottle change while dispensing
    switch_req = 1; e = b + 3001;
    wait_to(e);        chk("t2_bip_low", bip_a, 0);
    wait_to(e + 10);   switch_req = 0;
    wait_to(e + 1999);
    chk("t2_bip_still_low", bip_a, 0);
    chk("t2_no_pulse", pp_a, 0);
    chk("t2_bcd_held", pbcd_a, 12'h003);
    wait_to(e + 2000);
    chk("t2_bip_back", bip_a, 1);
    chk("t2_bottle_bcd", bbcd_a, 8'h01);
    chk("t2_state_dispense", u_a.state, 1);
    wait_to(e + 2001); chk("t2_resume_pulse", pp_a, 1); chk("t2_bcd4", pbcd_a, 12'h004);

    // 3: jam at end of move; pulse in flight completes across the state change
    switch_req = 1; m = e + 2002;
    wait_to(m);        chk("t3_moving", u_a.state, 2); chk("t3_pulse_kept", pp_a, 1);
    wait_to(m + 5);    switch_req = 0; run_req = 0; conveyor_stop = 1;
    wait_to(m + 6);    chk("t3_cok_low", cok_a, 0);
    wait_to(m + 98);   chk("t3_pulse_full", pp_a, 1);
    wait_to(m + 99);   chk("t3_pulse_done", pp_a, 0);
    wait_to(m + 1999); chk("t3_still_moving", u_a.state, 2);
    wait_to(m + 2000);
    chk("t3_jammed", u_a.state, 3);
    chk("t3_jam_bip", bip_a, 0);
    chk("t3_jam_cok", cok_a, 0);
    chk("t3_jam_bottle_bcd", bbcd_a, 8'h01);
    wait_to(m + 2010); conveyor_stop = 0;
    wait_to(m + 2011);
    chk("t3_release_bip", bip_a, 1);
    chk("t3_release_bcd", bbcd_a, 8'h02);
    chk("t3_release_idle", u_a.state, 0);
    chk("t3_cok_lag", cok_a, 0);
    wait_to(m + 2012); chk("t3_cok_back", cok_a, 1);

    // 5: hopper blocked, one manual pill
    hopper_stop = 1; run_req = 1; h = m + 2012;
    cnt = 0; rise = 0; prev = 0;
    for (int i = 1; i <= 1500; i++) begin
      @(negedge clk);
      if (i == 100) manual_add = 1;
      if (i == 110) manual_add = 0;
      if (pp_a) cnt++;
      if (pp_a && !prev && rise == 0) rise = i;
      prev = int'(pp_a);
    end
    chk("t5_high_cycles", cnt, 100);
    chk("t5_rise_time", rise, 103);
    chk("t5_bcd", pbcd_a, 12'h005);
    chk("t5_stock", u_a.stock, 496);
    hopper_stop = 0; run_req = 0;

    // 4: small stock runs dry, refill restarts it
    rst_b = 0; cyc(2);
    rst_b = 1; run_req = 1; c = pe;
    cnt = 0; rise = 0; prev = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (pp_b && !prev) begin cnt++; if (rise == 0) rise = i; end
      prev = int'(pp_b);
    end
    chk("t4_pulse_count", cnt, 2);
    chk("t4_first_rise", rise, 2);
    chk("t4_empty", emp_b, 1);
    chk("t4_bcd", pbcd_b, 12'h002);
    refill = 1;
    wait_to(c + 43);   chk("t4_refilled", u_b.stock, 2);
    wait_to(c + 44);   chk("t4_not_empty", emp_b, 0); refill = 0;
    wait_to(c + 49);   chk("t4_pre_resume", pp_b, 0);
    wait_to(c + 50);   chk("t4_resume", pp_b, 1); chk("t4_bcd3", pbcd_b, 12'h003);

    // 6: BCD wrap of both tallies, then async reset mid-move
    run_req = 0; rst_b = 0; cyc(2); rst_b = 1;
    for (int i = 0; i < 999; i++) begin
      manual_add = 1; cyc(3); manual_add = 0; cyc(3);
    end
    chk("t6_pill_999", pbcd_b, 12'h999);
    manual_add = 1; cyc(3); manual_add = 0; cyc(3);
    chk("t6_pill_wrap", pbcd_b, 12'h000);
    for (int i = 0; i < 99; i++) begin
      switch_req = 1; cyc(1); switch_req = 0; cyc(6);
    end
    chk("t6_bottle_99", bbcd_b, 8'h99);
    switch_req = 1; cyc(1); switch_req = 0; cyc(6);
    chk("t6_bottle_wrap", bbcd_b, 8'h00);
    chk("t6_bip", bip_b, 1);
    switch_req = 1; manual_add = 1; cyc(1); switch_req = 0; cyc(2);
    chk("t6_mid_pulse", pp_b, 1);
    chk("t6_mid_bip", bip_b, 0);
    chk("t6_mid_bcd", pbcd_b, 12'h001);
    #2 rst_b = 0;
    #1;
    chk("t6_rst_pulse", pp_b, 0);
    chk("t6_rst_bip", bip_b, 1);
    chk("t6_rst_cok", cok_b, 0);
    chk("t6_rst_empty", emp_b, 0);
    chk("t6_rst_pill_bcd", pbcd_b, 0);
    chk("t6_rst_bottle_bcd", bbcd_b, 0);
    chk("t6_rst_state", u_b.state, 0);
    manual_add = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
